// File: rtl/uart_eth_frame_ctrl.sv
// uart_eth_frame_ctrl: buffers UART bytes (rx_done_signal/rx_data) in a FIFO and streams them as zero-padded valid/ready frames (tx_valid/tx_ready/tx_data/tx_sof/tx_eof/tx_len), with sticky overflow and frame_cnt
module uart_eth_frame_ctrl #(
  parameter int DEPTH_LOG2   = 11,
  parameter int MAX_LEN      = 1024,
  parameter int MIN_LEN      = 46,
  parameter int IDLE_TIMEOUT = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done_signal,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic [10:0] tx_len,
  output logic        overflow,
  output logic [15:0] frame_cnt
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;
  state_t                r_state;
  logic [7:0]            r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [IW-1:0]         r_idle;
  logic [10:0]           r_pay, r_beat;
  logic                  w_wr, w_xfer, w_rd, w_trig;
  logic [10:0]           w_pay, w_len;
  logic [DEPTH_LOG2-1:0] w_rptr_nx;
  assign w_wr      = rx_done_signal && !r_count[DEPTH_LOG2];
  assign w_xfer    = tx_valid && tx_ready;
  assign w_rd      = w_xfer && r_state == SEND;
  assign w_rptr_nx = r_rptr + DEPTH_LOG2'(1);
  assign w_pay     = (32'(r_count) >= MAX_LEN) ? 11'(MAX_LEN) : 11'(r_count);
  assign w_len     = (w_pay < 11'(MIN_LEN)) ? 11'(MIN_LEN) : w_pay;
  assign w_trig    = r_state == IDLE && ((32'(r_count) >= MAX_LEN) || (r_count != '0 && r_idle == IW'(IDLE_TIMEOUT)));
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= rx_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_idle    <= '0;
      r_pay     <= '0;
      r_beat    <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      tx_sof    <= 1'b0;
      tx_eof    <= 1'b0;
      tx_len    <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_rd) r_rptr <= w_rptr_nx;
      r_count <= r_count + (DEPTH_LOG2+1)'(w_wr) - (DEPTH_LOG2+1)'(w_rd);
      if (rx_done_signal && r_count[DEPTH_LOG2]) overflow <= 1'b1;
      r_idle <= (rx_done_signal || w_trig) ? '0 : (r_idle == IW'(IDLE_TIMEOUT)) ? r_idle : r_idle + IW'(1);
      case (r_state)
        IDLE: if (w_trig) begin
          r_state  <= SEND;
          r_pay    <= w_pay;
          r_beat   <= 11'd1;
          tx_len   <= w_len;
          tx_valid <= 1'b1;
          tx_sof   <= 1'b1;
          tx_eof   <= w_len == 11'd1;
          tx_data  <= r_mem[r_rptr];
        end
        default: if (w_xfer) begin
          tx_sof <= 1'b0;
          if (r_beat == tx_len) begin
            r_state   <= IDLE;
            tx_valid  <= 1'b0;
            tx_eof    <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
          end else begin
            r_beat  <= r_beat + 11'd1;
            tx_eof  <= r_beat + 11'd1 == tx_len;
            r_state <= (r_beat < r_pay) ? SEND : PAD;
            tx_data <= (r_beat < r_pay) ? r_mem[w_rptr_nx] : 8'h00;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_eth_frame_ctrl.sv
// tb_uart_eth_frame_ctrl: random-stimulus bench checking uart_eth_frame_ctrl framing, padding, backpressure, overflow and reset against a byte-queue frame model
module tb_uart_eth_frame_ctrl;
  typedef struct packed {logic [7:0] d; logic s; logic e; logic [10:0] l;} beat_t;
  logic clk = 0, rst = 1, rx_done_signal = 0, tx_ready = 0;
  logic [7:0] rx_data = 0;
  logic tx_valid, tx_sof, tx_eof, overflow;
  logic [7:0] tx_data;
  logic [10:0] tx_len;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0, eof_seen = 0, rdy_mode = 0, m_frames = 0;
  logic m_ovf = 0;
  beat_t got_q[$];
  beat_t cur, p_beat;
  logic p_stall = 0, p_eofx = 0;
  uart_eth_frame_ctrl #(.DEPTH_LOG2(4), .MAX_LEN(8), .MIN_LEN(4), .IDLE_TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .rx_done_signal(rx_done_signal), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_len(tx_len),
    .overflow(overflow), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  always_comb cur = {tx_data, tx_sof, tx_eof, tx_len};
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) tx_ready = ~tx_ready;
    else if (rdy_mode == 2) tx_ready = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (!rst && p_stall && tx_valid) begin
      checks++;
      if (cur !== p_beat) begin
        errors++;
        $display("FAIL hold_stable got %h exp %h", cur, p_beat);
      end
    end
    if (!rst && p_eofx) begin
      checks++;
      if (tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_gap tx_valid got %b exp 0", tx_valid);
      end
    end
    if (!rst && tx_valid && tx_ready) begin
      got_q.push_back(cur);
      if (tx_eof) eof_seen++;
    end
    p_stall = !rst && tx_valid && !tx_ready;
    p_eofx  = !rst && tx_valid && tx_ready && tx_eof;
    p_beat  = cur;
  end
  task automatic write_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_done_signal = 1; rx_data = b;
    @(posedge clk); #1 rx_done_signal = 0;
  endtask
  task automatic run_scenario(input string name, input int n, input int gap, input int mode, input bit hold, input bit seq);
    logic [7:0] acc[$];
    beat_t exp_q[$];
    logic [7:0] b;
    int lat, nf, pay, ln, explat;
    got_q.delete();
    eof_seen = 0;
    rdy_mode = hold ? 0 : mode;
    tx_ready = !hold;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap - 2) @(posedge clk);
      b = seq ? 8'(i + 1) : 8'($urandom);
      write_byte(b);
      if (i < 16) acc.push_back(b);
      else m_ovf = 1;
    end
    if (!hold && n <= 8) begin
      explat = (n == 8) ? 2 : 22;
      lat = 0;
      while (lat < 100 && !tx_valid) begin @(negedge clk); lat++; end
      checks++;
      if (lat !== explat) begin
        errors++;
        $display("FAIL %s sof_latency got %0d exp %0d", name, lat, explat);
      end
    end
    if (hold) begin
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (overflow !== m_ovf) begin
        errors++;
        $display("FAIL %s overflow_held got %b exp %b", name, overflow, m_ovf);
      end
      rdy_mode = mode;
      tx_ready = 1;
    end
    nf = 0;
    while (acc.size() > 0) begin
      pay = acc.size() < 8 ? acc.size() : 8;
      ln  = pay < 4 ? 4 : pay;
      for (int k = 0; k < ln; k++) begin
        b = 8'h00;
        if (k < pay) b = acc.pop_front();
        exp_q.push_back({b, 1'(k == 0), 1'(k == ln - 1), 11'(ln)});
      end
      nf++;
    end
    m_frames += nf;
    for (int c = 0; c < 3000 && eof_seen < nf; c++) @(negedge clk);
    checks++;
    if (eof_seen !== nf) begin
      errors++;
      $display("FAIL %s eof_count got %0d exp %0d", name, eof_seen, nf);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s beat_count got %0d exp %0d", name, got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s beat%0d got %h exp %h", name, k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (frame_cnt !== 16'(m_frames)) begin
      errors++;
      $display("FAIL %s frame_cnt got %0d exp %0d", name, frame_cnt, m_frames);
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL %s overflow got %b exp %b", name, overflow, m_ovf);
    end
    rdy_mode = 0;
    tx_ready = 1;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset tx_valid got %b exp 0", tx_valid); end
    checks++; if (tx_sof !== 1'b0) begin errors++; $display("FAIL reset tx_sof got %b exp 0", tx_sof); end
    checks++; if (tx_eof !== 1'b0) begin errors++; $display("FAIL reset tx_eof got %b exp 0", tx_eof); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset tx_data got %h exp 00", tx_data); end
    checks++; if (tx_len !== 11'd0) begin errors++; $display("FAIL reset tx_len got %0d exp 0", tx_len); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow got %b exp 0", overflow); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset frame_cnt got %0d exp 0", frame_cnt); end
    @(posedge clk); #1 rst = 0;
  endtask
  task automatic test_frames;
    run_scenario("full8", 8, 10, 0, 0, 1);
    run_scenario("pad2", 2, 10, 0, 0, 0);
    run_scenario("nopad5", 5, 10, 0, 0, 0);
    run_scenario("toggle5", 5, 10, 1, 0, 0);
  endtask
  task automatic test_overflow;
    run_scenario("overflow", 17, 2, 0, 1, 0);
  endtask
  task automatic test_back_to_back;
    run_scenario("back_to_back", 16, 2, 0, 0, 0);
  endtask
  task automatic test_random;
    for (int it = 0; it < 4; it++)
      run_scenario("random", int'($urandom_range(1, 16)), int'($urandom_range(2, 15)), 2, 0, 0);
  endtask
  task automatic test_reset_mid_frame;
    logic [7:0] b[8];
    int c;
    got_q.delete();
    eof_seen = 0;
    rdy_mode = 0;
    tx_ready = 0;
    for (int i = 0; i < 8; i++) begin
      b[i] = 8'($urandom);
      write_byte(b[i]);
    end
    c = 0;
    while (c < 50 && !tx_valid) begin @(negedge clk); c++; end
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL rst_mid sof_wait got %b exp 1", tx_valid); end
    @(posedge clk); #1 tx_ready = 1;
    @(posedge clk);
    @(posedge clk); #1 tx_ready = 0; rst = 1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== b[2] || tx_sof !== 1'b0 || tx_eof !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid third_beat got v%b d%h s%b e%b exp v1 d%h s0 e0", tx_valid, tx_data, tx_sof, tx_eof, b[2]);
    end
    @(posedge clk); #1 rst = 0;
    m_frames = 0;
    m_ovf = 0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid tx_valid got %b exp 0", tx_valid); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid overflow got %b exp 0", overflow); end
    checks++; if (eof_seen !== 0) begin errors++; $display("FAIL rst_mid eof_seen got %0d exp 0", eof_seen); end
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL rst_mid beats got %0d exp 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {b[0], 1'b1, 1'b0, 11'd8} || got_q[1] !== {b[1], 1'b0, 1'b0, 11'd8}) begin
        errors++;
        $display("FAIL rst_mid beat_data got %h %h exp %h %h", got_q[0], got_q[1], {b[0], 1'b1, 1'b0, 11'd8}, {b[1], 1'b0, 1'b0, 11'd8});
      end
    end
    run_scenario("after_rst", 4, 3, 0, 0, 0);
  endtask
  initial begin
    test_reset;
    test_frames;
    test_overflow;
    test_back_to_back;
    test_random;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
